// File: rtl/ysyx_22050058_div.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050058_div
// Purpose  : Multi-cycle radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU
//            and their W variants. Holds the EX stall request while busy.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050058_div #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            div_valid_i,
   input  logic [1:0]      div_op_i,
   input  logic            div_word_i,
   input  logic [XLEN-1:0] div_a_i,
   input  logic [XLEN-1:0] div_b_i,
   input  logic            div_flush_i,
   output logic            div_stall_req_o,
   output logic [XLEN-1:0] div_result_o,
   output logic            div_done_o
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [CW-1:0] c_n_word = CW'(32);
   localparam logic [CW-1:0] c_n_full = CW'(XLEN);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_cnt;
   logic [XLEN-1:0] r_rem;
   logic [XLEN-1:0] r_quo;
   logic [XLEN-1:0] r_div;
   logic [XLEN-1:0] r_result;
   logic            r_done;
   logic            r_word;
   logic            r_rem_op;
   logic            r_neg_q;
   logic            r_neg_r;

   logic            w_signed;
   logic            w_rem_op;
   logic [XLEN-1:0] w_a_ext;
   logic [XLEN-1:0] w_b_ext;
   logic            w_sa;
   logic            w_sb;
   logic [XLEN-1:0] w_min;
   logic            w_b_zero;
   logic            w_ovf;
   logic [XLEN-1:0] w_abs_a;
   logic [XLEN-1:0] w_abs_b;
   logic [XLEN-1:0] w_quo_init;
   logic [XLEN-1:0] w_spec_val;
   logic [XLEN:0]   w_shift;
   logic            w_ge;
   logic [XLEN-1:0] w_rem_nx;
   logic [XLEN-1:0] w_quo_nx;
   logic [XLEN-1:0] w_q_fin;
   logic [XLEN-1:0] w_r_fin;
   logic [XLEN-1:0] w_fin;

   // W results are the low word sign-extended to the full datapath
   function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] val, input logic word);
      fmt = word ? {{(XLEN-32){val[31]}}, val[31:0]} : val;
   endfunction

   assign w_signed = div_op_i[1];
   assign w_rem_op = div_op_i[0];

   // Operand extension, special-case detection and absolute values for issue
   always_comb begin
      w_a_ext = div_a_i;
      w_b_ext = div_b_i;
      w_min   = {1'b1, {(XLEN-1){1'b0}}};
      if (div_word_i) begin
         w_a_ext = w_signed ? {{(XLEN-32){div_a_i[31]}}, div_a_i[31:0]}
                            : {{(XLEN-32){1'b0}}, div_a_i[31:0]};
         w_b_ext = w_signed ? {{(XLEN-32){div_b_i[31]}}, div_b_i[31:0]}
                            : {{(XLEN-32){1'b0}}, div_b_i[31:0]};
         w_min   = {{(XLEN-31){1'b1}}, 31'b0};
      end
      w_sa       = w_signed & w_a_ext[XLEN-1];
      w_sb       = w_signed & w_b_ext[XLEN-1];
      w_b_zero   = (w_b_ext == '0);
      w_ovf      = w_signed & (&w_b_ext) & (w_a_ext == w_min);
      w_abs_a    = w_sa ? -w_a_ext : w_a_ext;
      w_abs_b    = w_sb ? -w_b_ext : w_b_ext;
      // Left-align a W dividend so the top bit feeds the remainder first
      w_quo_init = div_word_i ? {w_abs_a[31:0], {(XLEN-32){1'b0}}} : w_abs_a;
      if (w_b_zero)
         w_spec_val = w_rem_op ? w_a_ext : '1;
      else
         w_spec_val = w_rem_op ? '0 : w_a_ext;
   end

   // One restoring step plus sign fix-up of the step's outcome
   always_comb begin
      w_shift  = {r_rem, r_quo[XLEN-1]};
      w_ge     = (w_shift >= {1'b0, r_div});
      w_rem_nx = w_ge ? (w_shift[XLEN-1:0] - r_div) : w_shift[XLEN-1:0];
      w_quo_nx = {r_quo[XLEN-2:0], w_ge};
      w_q_fin  = r_neg_q ? -w_quo_nx : w_quo_nx;
      w_r_fin  = r_neg_r ? -w_rem_nx : w_rem_nx;
      w_fin    = fmt(r_rem_op ? w_r_fin : w_q_fin, r_word);
   end

   // Next-state logic; flush forces IDLE from any state
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (div_valid_i) w_next = (w_b_zero | w_ovf) ? S_DONE : S_BUSY;
         S_BUSY: if (r_cnt == CW'(1)) w_next = S_DONE;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (div_flush_i) w_next = S_IDLE;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Datapath: operand latch, iteration and result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
         r_word   <= 1'b0;
         r_rem_op <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
      end else begin
         r_done <= (w_next == S_DONE);
         if (!div_flush_i) begin
            case (r_state)
               S_IDLE: begin
                  if (div_valid_i) begin
                     r_word   <= div_word_i;
                     r_rem_op <= w_rem_op;
                     r_neg_q  <= w_sa ^ w_sb;
                     r_neg_r  <= w_sa;
                     if (w_b_zero | w_ovf) begin
                        r_result <= fmt(w_spec_val, div_word_i);
                     end else begin
                        r_cnt <= div_word_i ? c_n_word : c_n_full;
                        r_rem <= '0;
                        r_quo <= w_quo_init;
                        r_div <= w_abs_b;
                     end
                  end
               end
               S_BUSY: begin
                  r_rem <= w_rem_nx;
                  r_quo <= w_quo_nx;
                  r_cnt <= r_cnt - CW'(1);
                  if (r_cnt == CW'(1)) r_result <= w_fin;
               end
               default: ;
            endcase
         end
      end
   end

   assign div_done_o      = r_done;
   assign div_result_o    = r_result;
   assign div_stall_req_o = div_valid_i & ~r_done & ~div_flush_i;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050058_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22050058_div
// Purpose  : Scoreboard bench for ysyx_22050058_div with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050058_div;

   localparam int XLEN = 64;

   logic            clk;
   logic            rst;
   logic            div_valid_i;
   logic [1:0]      div_op_i;
   logic            div_word_i;
   logic [XLEN-1:0] div_a_i;
   logic [XLEN-1:0] div_b_i;
   logic            div_flush_i;
   logic            div_stall_req_o;
   logic [XLEN-1:0] div_result_o;
   logic            div_done_o;

   typedef struct {
      logic [XLEN-1:0] res;
      int              t0;
      int              lat;
   } exp_t;

   exp_t q_exp[$];
   int   cyc;
   int   n_checks;
   int   n_pass;

   ysyx_22050058_div #(.XLEN(XLEN)) dut (
      .clk             (clk),
      .rst             (rst),
      .div_valid_i     (div_valid_i),
      .div_op_i        (div_op_i),
      .div_word_i      (div_word_i),
      .div_a_i         (div_a_i),
      .div_b_i         (div_b_i),
      .div_flush_i     (div_flush_i),
      .div_stall_req_o (div_stall_req_o),
      .div_result_o    (div_result_o),
      .div_done_o      (div_done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   // Monitor: each done pulse must match the oldest expected result
   always @(negedge clk) begin
      if (!rst && div_done_o) begin
         if (q_exp.size() == 0) begin
            chk("unexpected_done", 64'(div_done_o), 64'd0);
         end else begin
            exp_t e;
            e = q_exp.pop_front();
            chk("result", div_result_o, e.res);
            chk("latency", 64'(cyc - e.t0), 64'(e.lat));
            chk("stall_at_done", 64'(div_stall_req_o), 64'd0);
         end
      end
   end

   // Issue one divide, hold valid until done, count stall cycles
   task automatic do_div(input logic [1:0] op, input logic word, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res, input int lat);
      exp_t e;
      int   stalls;
      bit   seen;
      @(posedge clk); #1;
      div_valid_i = 1'b1;
      div_op_i    = op;
      div_word_i  = word;
      div_a_i     = a;
      div_b_i     = b;
      e.res = exp_res; e.t0 = cyc; e.lat = lat;
      q_exp.push_back(e);
      stalls = 0;
      seen   = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         if (div_stall_req_o) stalls++;
         if (div_done_o) seen = 1'b1;
      end
      chk("done_seen", 64'(seen), 64'd1);
      chk("stall_cycles", 64'(stalls), 64'(lat));
      @(posedge clk); #1;
      div_valid_i = 1'b0;
   endtask

   initial begin
      n_checks = 0; n_pass = 0; cyc = 0;
      rst = 1'b1; div_valid_i = 1'b0; div_op_i = 2'b00; div_word_i = 1'b0;
      div_a_i = '0; div_b_i = '0; div_flush_i = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_done", 64'(div_done_o), 64'd0);
      chk("reset_result", div_result_o, 64'd0);
      chk("reset_stall", 64'(div_stall_req_o), 64'd0);
      @(posedge clk); #1; rst = 1'b0;

      do_div(2'b00, 1'b0, 64'd100, 64'd7, 64'd14, 65);
      do_div(2'b01, 1'b0, 64'd100, 64'd7, 64'd2, 65);
      do_div(2'b10, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
      do_div(2'b11, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
      do_div(2'b11, 1'b0, 64'd7, -64'sd2, 64'd1, 65);
      do_div(2'b10, 1'b0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65);
      do_div(2'b11, 1'b0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65);
      do_div(2'b10, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      do_div(2'b01, 1'b0, 64'd5, 64'd0, 64'd5, 1);
      do_div(2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
      do_div(2'b10, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
      do_div(2'b11, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
      do_div(2'b10, 1'b1, 64'h1_0000_0064, 64'd7, 64'd14, 33);
      do_div(2'b00, 1'b1, 64'hFFFF_FFFF, 64'd2, 64'h7FFF_FFFF, 33);

      // Flush at cycle 10 of a 64-bit divide
      @(posedge clk); #1;
      div_valid_i = 1'b1; div_op_i = 2'b00; div_word_i = 1'b0;
      div_a_i = 64'd1000; div_b_i = 64'd3;
      repeat (10) @(posedge clk);
      #1 div_flush_i = 1'b1;
      @(negedge clk);
      chk("flush_stall", 64'(div_stall_req_o), 64'd0);
      @(posedge clk); #1;
      div_flush_i = 1'b0; div_valid_i = 1'b0;
      repeat (80) @(negedge clk);
      chk("flush_no_done", 64'(div_done_o), 64'd0);
      do_div(2'b00, 1'b0, 64'd9, 64'd3, 64'd3, 65);

      // Reset pulse in the middle of a divide
      @(posedge clk); #1;
      div_valid_i = 1'b1; div_op_i = 2'b00; div_a_i = 64'd50; div_b_i = 64'd5;
      repeat (20) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; div_valid_i = 1'b0;
      @(negedge clk);
      chk("rst_result", div_result_o, 64'd0);
      chk("rst_done", 64'(div_done_o), 64'd0);
      repeat (80) @(negedge clk);
      chk("rst_no_done", 64'(div_done_o), 64'd0);
      chk("queue_empty", 64'(q_exp.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
